// File: rtl/count_game_ctrl.sv
// Count-game sequencer: debounced start/hit keys drive a 6,5..1,0 countdown, reaction timing and grading; all outputs registered, one-cycle FSM latency after a key pulse.
// No backpressure: keys are sampled every cycle. Optional best-score register is built only when BEST_SCORE_EN is defined.
module count_game_ctrl #(
  parameter int TICK_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int GO_TIMEOUT      = 2000,
  parameter int HOLD_CYCLES     = 3000,
  parameter int TH_FAST         = 250,
  parameter int TH_MID          = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_start,
  input  logic        key_hit,
  output logic [2:0]  num,
  output logic [11:0] react_ms,
  output logic        react_valid,
  output logic        foul,
  output logic [11:0] best_ms
);

  localparam int MAXC = (TICK_CYCLES > HOLD_CYCLES)
                      ? ((TICK_CYCLES > GO_TIMEOUT) ? TICK_CYCLES : GO_TIMEOUT)
                      : ((HOLD_CYCLES > GO_TIMEOUT) ? HOLD_CYCLES : GO_TIMEOUT);
  localparam int TW = ($clog2(MAXC) > 12) ? $clog2(MAXC) : 12;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] GO_LAST   = TW'(GO_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [11:0]   TH_FAST_L = 12'(TH_FAST);
  localparam logic [11:0]   TH_MID_L  = 12'(TH_MID);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_GO, S_RESULT, S_FOUL} state_t;

  // Bit 0 = start key, bit 1 = hit key.
  logic [1:0]    key_raw;
  logic [1:0]    sync1_q, sync2_q, lvl_q, pulse_q;
  logic [DW-1:0] db_cnt_q [2];
  logic          start_p, hit_p;

  assign key_raw = {key_hit, key_start};
  assign start_p = pulse_q[0];
  assign hit_p   = pulse_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      for (int k = 0; k < 2; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      pulse_q <= '0;
      for (int k = 0; k < 2; k++) begin
        if (sync2_q[k] == lvl_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_LAST) begin
          db_cnt_q[k] <= '0;
          lvl_q[k]    <= sync2_q[k];
          pulse_q[k]  <= sync2_q[k];
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  function automatic logic [2:0] grade(input logic [11:0] ms);
    if (ms < TH_FAST_L)     return 3'd1;
    else if (ms < TH_MID_L) return 3'd2;
    else                    return 3'd3;
  endfunction

  state_t        state_q;
  logic [2:0]    num_q;
  logic [TW-1:0] timer_q;
  logic [11:0]   react_q;
  logic          valid_q;
  logic          foul_q;

  // One shared timer: countdown tick, reaction count and display hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      num_q   <= 3'd6;
      timer_q <= '0;
      react_q <= '0;
      valid_q <= 1'b0;
      foul_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_p) begin
            state_q <= S_COUNT;
            num_q   <= 3'd5;
            timer_q <= '0;
          end
        end
        S_COUNT: begin
          if (hit_p) begin
            state_q <= S_FOUL;
            num_q   <= 3'd6;
            foul_q  <= 1'b1;
            timer_q <= '0;
          end else if (timer_q == TICK_LAST) begin
            timer_q <= '0;
            if (num_q > 3'd1) begin
              num_q <= num_q - 3'd1;
            end else begin
              state_q <= S_GO;
              num_q   <= 3'd0;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_GO: begin
          // A hit on the timeout cycle still captures the real count.
          if (hit_p || timer_q == GO_LAST) begin
            state_q <= S_RESULT;
            valid_q <= 1'b1;
            react_q <= hit_p ? timer_q[11:0] : 12'hFFF;
            num_q   <= hit_p ? grade(timer_q[11:0]) : 3'd4;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_RESULT: begin
          if (start_p) begin
            state_q <= S_COUNT;
            num_q   <= 3'd5;
            timer_q <= '0;
          end else if (timer_q == HOLD_LAST) begin
            state_q <= S_IDLE;
            num_q   <= 3'd6;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_FOUL: begin
          if (timer_q == HOLD_LAST) begin
            state_q <= S_IDLE;
            foul_q  <= 1'b0;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          num_q   <= 3'd6;
          foul_q  <= 1'b0;
          timer_q <= '0;
        end
      endcase
    end
  end

  assign num         = num_q;
  assign react_ms    = react_q;
  assign react_valid = valid_q;
  assign foul        = foul_q;

`ifdef BEST_SCORE_EN
  logic [11:0] best_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= 12'hFFF;
    end else if (state_q == S_GO && hit_p && timer_q[11:0] < best_q) begin
      best_q <= timer_q[11:0];
    end
  end

  assign best_ms = best_q;
`else
  assign best_ms = 12'hFFF;
`endif

endmodule

// File: tb/tb_count_game_ctrl.sv
// Self-checking bench for count_game_ctrl with small timing parameters.
module tb_count_game_ctrl;

  localparam int TICK = 10;
  localparam int DEB  = 3;
  localparam int GOT  = 40;
  localparam int HOLD = 20;
  // Key press to pulse cycle: 2 sync flops + DEB stable cycles.
  localparam int KEY_LAT = 2 + DEB;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_start;
  logic        key_hit;
  logic [2:0]  num;
  logic [11:0] react_ms;
  logic        react_valid;
  logic        foul;
  logic [11:0] best_ms;

  count_game_ctrl #(
    .TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB), .GO_TIMEOUT(GOT),
    .HOLD_CYCLES(HOLD), .TH_FAST(5), .TH_MID(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_start(key_start), .key_hit(key_hit),
    .num(num), .react_ms(react_ms), .react_valid(react_valid),
    .foul(foul), .best_ms(best_ms)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ms;
    logic [2:0]  num;
  } exp_t;

  typedef struct {
    int          r;        // GO cycle of hit pulse, -1 = no hit
    logic [11:0] exp_ms;
    logic [2:0]  exp_num;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          seen7    = 0;
  logic [11:0] exp_best = 12'hFFF;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_num(input logic [2:0] v, input int budget, input string name);
    int i = 0;
    while (num !== v && i < budget) begin
      tick(1);
      i++;
    end
    check(name, 12'(num), 12'(v));
  endtask

  task automatic push(input logic [11:0] ms, input logic [2:0] g);
    exp_t e;
    e.ms  = ms;
    e.num = g;
    sb_q.push_back(e);
`ifdef BEST_SCORE_EN
    if (ms != 12'hFFF && ms < exp_best) exp_best = ms;
`endif
  endtask

  // Start press held for KEY_LAT+1 cycles; returns on the first num=5 cycle.
  task automatic press_start();
    key_start = 1'b1;
    tick(KEY_LAT + 1);
    key_start = 1'b0;
    check("start_to_5", 12'(num), 12'd5);
  endtask

  always @(negedge clk) begin
    if (num == 3'd7) seen7++;
    if (rst_n && react_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 12'd1, 12'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("react_ms", react_ms, e.ms);
        check("grade_num", 12'(num), 12'(e.num));
      end
    end
  end

  initial begin
    int cnt;
    vecs[0] = '{r: 0,  exp_ms: 12'd0,   exp_num: 3'd1};
    vecs[1] = '{r: 4,  exp_ms: 12'd4,   exp_num: 3'd1};
    vecs[2] = '{r: 5,  exp_ms: 12'd5,   exp_num: 3'd2};
    vecs[3] = '{r: 14, exp_ms: 12'd14,  exp_num: 3'd2};
    vecs[4] = '{r: 15, exp_ms: 12'd15,  exp_num: 3'd3};
    vecs[5] = '{r: 39, exp_ms: 12'd39,  exp_num: 3'd3};
    vecs[6] = '{r: -1, exp_ms: 12'hFFF, exp_num: 3'd4};

    rst_n = 1'b0; key_start = 1'b0; key_hit = 1'b0;
    tick(2);
    check("rst_num", 12'(num), 12'd6);
    check("rst_react_ms", react_ms, 12'd0);
    check("rst_valid", 12'(react_valid), 12'd0);
    check("rst_foul", 12'(foul), 12'd0);
    check("rst_best", best_ms, 12'hFFF);
    rst_n = 1'b1;
    tick(2);

    // Countdown: each digit 5..1 held exactly TICK cycles.
    key_start = 1'b1;
    tick(KEY_LAT);
    check("pre_start_6", 12'(num), 12'd6);
    tick(1);
    key_start = 1'b0;
    check("first_5", 12'(num), 12'd5);
    for (int d = 5; d >= 1; d--) begin
      cnt = 0;
      for (int i = 0; i < TICK; i++) begin
        if (num == 3'(d)) cnt++;
        tick(1);
      end
      check($sformatf("digit_%0d_len", d), 12'(cnt), 12'(TICK));
    end
    check("go_entered", 12'(num), 12'd0);

    // Hit pulse at react_cnt = 7; result held HOLD cycles.
    tick(7 - KEY_LAT);
    key_hit = 1'b1;
    push(12'd7, 3'd2);
    tick(KEY_LAT + 1);
    check("valid_at_8", 12'(react_valid), 12'd1);
    key_hit = 1'b0;
    cnt = 0;
    for (int i = 0; i < HOLD; i++) begin
      if (num == 3'd2) cnt++;
      tick(1);
    end
    check("result_hold_len", 12'(cnt), 12'(HOLD));
    check("result_to_idle", 12'(num), 12'd6);
    check("best_after_7", best_ms, exp_best);

    // Timeout with a 2-cycle-period bouncing hit key.
    press_start();
    wait_num(3'd0, 100, "to_go_timeout");
    push(12'hFFF, 3'd4);
    for (int i = 0; i < 30; i++) begin
      key_hit = (i % 2 == 0);
      tick(1);
    end
    key_hit = 1'b0;
    tick(GOT - 30);
    check("timeout_valid", 12'(react_valid), 12'd1);
    check("timeout_best", best_ms, exp_best);
    wait_num(3'd6, 100, "timeout_to_idle");
    check("react_held_idle", react_ms, 12'hFFF);

    // Grading table.
    for (int v = 0; v < 7; v++) begin
      press_start();
      wait_num(3'd1, 100, "to_num1");
      if (vecs[v].r >= 0) begin
        tick(vecs[v].r + TICK - KEY_LAT);
        key_hit = 1'b1;
      end
      push(vecs[v].exp_ms, vecs[v].exp_num);
      wait_num(3'd6, 150, $sformatf("vec%0d_idle", v));
      key_hit = 1'b0;
      check($sformatf("vec%0d_held", v), react_ms, vecs[v].exp_ms);
      check($sformatf("vec%0d_best", v), best_ms, exp_best);
      tick(KEY_LAT + 2);
    end

    // Foul at num=3; start ignored while fouled.
    press_start();
    wait_num(3'd3, 100, "to_num3");
    key_hit = 1'b1;
    tick(KEY_LAT + 1);
    check("foul_set", 12'(foul), 12'd1);
    key_start = 1'b1;
    cnt = 0;
    for (int i = 0; i < HOLD; i++) begin
      if (foul && num == 3'd6) cnt++;
      if (i == KEY_LAT + 1) begin key_start = 1'b0; key_hit = 1'b0; end
      tick(1);
    end
    check("foul_len", 12'(cnt), 12'(HOLD));
    check("foul_cleared", 12'(foul), 12'd0);
    tick(10);
    check("start_ignored_foul", 12'(num), 12'd6);

    // Start during RESULT restarts the countdown at once.
    press_start();
    wait_num(3'd1, 100, "to_num1_r");
    tick(3 + TICK - KEY_LAT);
    key_hit = 1'b1;
    push(12'd3, 3'd1);
    tick(KEY_LAT + 1);
    key_hit = 1'b0;
    key_start = 1'b1;
    tick(KEY_LAT);
    check("result_before_start", 12'(num), 12'd1);
    tick(1);
    key_start = 1'b0;
    check("result_start_5", 12'(num), 12'd5);

    // Start and hit together in COUNT: hit wins.
    tick(KEY_LAT + 3);
    key_start = 1'b1;
    key_hit   = 1'b1;
    tick(KEY_LAT + 1);
    check("both_in_count_foul", 12'(foul), 12'd1);
    key_start = 1'b0;
    key_hit   = 1'b0;
    cnt = 0;
    while (foul && cnt < 40) begin
      tick(1);
      cnt++;
    end
    check("both_foul_ends", 12'(foul), 12'd0);

    // Start and hit together in IDLE: start wins.
    tick(KEY_LAT + 2);
    key_start = 1'b1;
    key_hit   = 1'b1;
    tick(KEY_LAT + 1);
    check("both_idle_num", 12'(num), 12'd5);
    check("both_idle_foul", 12'(foul), 12'd0);
    key_start = 1'b0;
    key_hit   = 1'b0;

    // Asynchronous reset mid-countdown.
    wait_num(3'd3, 100, "to_num3_rst");
    rst_n = 1'b0;
    #1;
    check("async_rst_num", 12'(num), 12'd6);
    check("async_rst_react", react_ms, 12'd0);
    check("async_rst_best", best_ms, 12'hFFF);
    exp_best = 12'hFFF;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    press_start();
    tick(3);

    check("no_num7", 12'(seen7), 12'd0);
    check("sb_empty", 12'(sb_q.size()), 12'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
